pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS-style pipeline. It sits beside the ID stage and drives PC/IF-ID write enables, the ID-stage control-bubble mux, and the IF-ID/ID-EXE flush lines. It generalises load-use stalling to a configurable load-to-use distance via a stall counter FSM. It adds taken-branch flushing, a full-pipeline freeze while data memory is not ready, and saturating stall/flush performance counters.

## Interface
- REG_AW, 5: register-address width.
- LOAD_STALL, 1: bubble cycles inserted per load-use hazard; legal range 1..7.
- PERF_W, 16: width of each performance counter.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-low reset.
- IFID_regRs  in  REG_AW  Rs of the instruction in ID.
- IFID_regRt  in  REG_AW  Rt of the instruction in ID.
- IFID_useRs  in  1  ID instruction reads Rs.
- IFID_useRt  in  1  ID instruction reads Rt.
- IDEXE_regRd  in  REG_AW  destination of the instruction in EXE.
- IDEXE_memRead  in  1  EXE instruction is a load.
- branch_taken_i  in  1  branch/jump resolved taken in EXE this cycle.
- dmem_ready_i  in  1  data memory can complete this cycle.
- PC_write  out  1  PC update enable.
- IFID_write  out  1  IF-ID register write enable.
- control_output_select  out  1  1 = inject a zero-control bubble into ID-EXE.
- IFID_flush_o  out  1  clear IF-ID.
- IDEXE_flush_o  out  1  clear ID-EXE.
- pipe_freeze_o  out  1  hold ID-EXE, EXE-MEM and MEM-WB.
- stall_cnt_o  out  PERF_W  count of load-use bubble cycles, saturating.
- flush_cnt_o  out  PERF_W  count of taken-branch flushes, saturating.

## Operation
- Hazard hit: IDEXE_memRead && IDEXE_regRd != 0 && ((IFID_useRs && Rd==Rs) || (IFID_useRt && Rd==Rt)).
- FSM states are IDLE and LU_STALL, with a 3-bit counter cnt.
- IDLE, hit, no flush, dmem ready:
  - Assert stall this cycle: PC_write=0, IFID_write=0, control_output_select=1.
  - If LOAD_STALL>1, go to LU_STALL with cnt=LOAD_STALL-1. Otherwise stay in IDLE.
- LU_STALL:
  - Assert stall every cycle, independent of the hit inputs, because ID is held.
  - cnt decrements each cycle; when cnt==1, return to IDLE on this edge.
- Freeze: dmem_ready_i=0 overrides everything.
  - pipe_freeze_o=1, PC_write=0, IFID_write=0.
  - control_output_select=0, both flushes 0.
  - FSM state, cnt and counters hold.
- Flush: branch_taken_i=1 with dmem ready.
  - IFID_flush_o=1, IDEXE_flush_o=1, PC_write=1, IFID_write=0, control_output_select=0.
  - FSM goes to IDLE and cnt to 0, aborting any stall; the stalled instruction is wrong-path.
- Priority: freeze > flush > stall > normal.
- Normal: PC_write=1, IFID_write=1, all other control outputs 0.
- stall_cnt_o increments on each cycle with control_output_select=1. flush_cnt_o increments on each flush cycle. Both saturate at all-ones.

## Timing
- Stall, bubble, flush and freeze outputs are combinational from the inputs and state; there is no added latency.
- LOAD_STALL=1 reproduces classic single-bubble behaviour exactly, with no FSM excursion.
- A load-use hazard yields exactly LOAD_STALL consecutive stall cycles when there is no freeze or flush. Freeze cycles stretch this and are not counted.
- Counters update on the edge ending the qualifying cycle.
- While rst_i=0:
  - PC_write=0, IFID_write=0, control_output_select=0, both flushes 0, pipe_freeze_o=0.
  - On the edge: state=IDLE, cnt=0, counters=0.
- Reset mid-stall abandons the stall. The first cycle after reset is a normal IDLE evaluation.

## Structure
- Shared package pipe_pkg holds:
  - REG_AW default and the REG_ZERO constant.
  - Typedef hz_state_t {HZ_IDLE, HZ_LU_STALL}.
- Sub-module sat_counter (parameter W, inputs inc/clr) is instantiated twice for the performance counters.
- Priority resolution and hit compare stay in one always_comb block; the FSM and cnt sit in one always_ff block.

## Test plan
- LOAD_STALL=1, lw $2 in EXE, ID reads Rs=2 -> one cycle PC_write=0, control_output_select=1; stall_cnt_o=1.
- LOAD_STALL=3, same hazard -> three consecutive stall cycles, then PC_write=1 on cycle 4; stall_cnt_o=3.
- Load to $0 with ID Rs=0, and a load with Rd=Rt but IFID_useRt=0 -> no stall in either case.
- LOAD_STALL=3 with dmem_ready_i=0 for 2 cycles during the second stall cycle -> pipe_freeze_o=1 for 2 cycles, then 2 more stall cycles; stall_cnt_o=3.
- branch_taken_i=1 coincident with a hazard hit, or in LU_STALL -> both flushes=1, control_output_select=0, next state IDLE; flush_cnt_o increments by 1.
- PERF_W=4 with 20 stall cycles -> stall_cnt_o=15. Assert rst_i=0 mid-stall -> all outputs follow the reset values, counters=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and types for the pipeline hazard controller.
package pipe_pkg;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    typedef enum logic {HZ_IDLE, HZ_LU_STALL} hz_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID-stage hazard inputs and pipeline control outputs.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = pipe_pkg::REG_AW,
    parameter int PERF_W = 16
);
    logic [REG_AW-1:0] IFID_regRs;
    logic [REG_AW-1:0] IFID_regRt;
    logic              IFID_useRs;
    logic              IFID_useRt;
    logic [REG_AW-1:0] IDEXE_regRd;
    logic              IDEXE_memRead;
    logic              branch_taken_i;
    logic              dmem_ready_i;
    logic              PC_write;
    logic              IFID_write;
    logic              control_output_select;
    logic              IFID_flush_o;
    logic              IDEXE_flush_o;
    logic              pipe_freeze_o;
    logic [PERF_W-1:0] stall_cnt_o;
    logic [PERF_W-1:0] flush_cnt_o;

    modport master (
        output IFID_regRs, IFID_regRt, IFID_useRs, IFID_useRt, IDEXE_regRd,
               IDEXE_memRead, branch_taken_i, dmem_ready_i,
        input  PC_write, IFID_write, control_output_select, IFID_flush_o,
               IDEXE_flush_o, pipe_freeze_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  IFID_regRs, IFID_regRt, IFID_useRs, IFID_useRt, IDEXE_regRd,
               IDEXE_memRead, branch_taken_i, dmem_ready_i,
        output PC_write, IFID_write, control_output_select, IFID_flush_o,
               IDEXE_flush_o, pipe_freeze_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: synchronous-clear up-counter that sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (inc && !(&q))
            q <= q + 1'b1;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall FSM, branch flush and dmem freeze control
// for a 5-stage pipeline, with saturating stall/flush counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW     = pipe_pkg::REG_AW,
    parameter int LOAD_STALL = 1,
    parameter int PERF_W     = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    pipe_hazard_ctrl_if.slave hz
);
    localparam logic [2:0] CNT_INIT = 3'(LOAD_STALL - 1);

    hz_state_t  state;
    logic [2:0] cnt;
    logic       hit;
    logic       stall;
    logic       flush;

    always_comb begin
        hit = hz.IDEXE_memRead && (hz.IDEXE_regRd != REG_AW'(REG_ZERO)) &&
              ((hz.IFID_useRs && hz.IDEXE_regRd == hz.IFID_regRs) ||
               (hz.IFID_useRt && hz.IDEXE_regRd == hz.IFID_regRt));
        flush = rst_i && hz.dmem_ready_i && hz.branch_taken_i;
        // LU_STALL keeps stalling regardless of hit: the ID instruction is held.
        stall = rst_i && hz.dmem_ready_i && !hz.branch_taken_i &&
                (state == HZ_LU_STALL || hit);
        hz.pipe_freeze_o = rst_i && !hz.dmem_ready_i;
        hz.PC_write = rst_i && hz.dmem_ready_i && !stall;
        hz.IFID_write = rst_i && hz.dmem_ready_i && !stall && !hz.branch_taken_i;
        hz.control_output_select = stall;
        hz.IFID_flush_o = flush;
        hz.IDEXE_flush_o = flush;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= HZ_IDLE;
            cnt   <= '0;
        end else if (hz.dmem_ready_i) begin
            if (hz.branch_taken_i) begin
                state <= HZ_IDLE;
                cnt   <= '0;
            end else if (state == HZ_LU_STALL) begin
                cnt   <= cnt - 1'b1;
                state <= (cnt == 3'd1) ? HZ_IDLE : HZ_LU_STALL;
            end else if (hit && LOAD_STALL > 1) begin
                state <= HZ_LU_STALL;
                cnt   <= CNT_INIT;
            end
        end
    end

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk (clk_i),
        .clr (!rst_i),
        .inc (hz.control_output_select),
        .q   (hz.stall_cnt_o)
    );

    sat_counter #(.W(PERF_W)) u_flush_cnt (
        .clk (clk_i),
        .clr (!rst_i),
        .inc (hz.IFID_flush_o),
        .q   (hz.flush_cnt_o)
    );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: two controllers (LOAD_STALL=1/PERF_W=16, LOAD_STALL=3/PERF_W=4)
// driven in lockstep and compared against a remaining-bubbles reference model.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs, rt, rd;
    logic       urs, urt, mr, br, rdy;
    int         checks = 0;
    int         failures = 0;
    int         rem [2];
    int         sc [2];
    int         fc [2];
    int         ls [2] = '{1, 3};
    int         mx [2] = '{65535, 15};

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(5), .PERF_W(16)) ia ();
    pipe_hazard_ctrl_if #(.REG_AW(5), .PERF_W(4))  ib ();

    always_comb begin
        ia.IFID_regRs = rs;  ib.IFID_regRs = rs;
        ia.IFID_regRt = rt;  ib.IFID_regRt = rt;
        ia.IFID_useRs = urs; ib.IFID_useRs = urs;
        ia.IFID_useRt = urt; ib.IFID_useRt = urt;
        ia.IDEXE_regRd = rd; ib.IDEXE_regRd = rd;
        ia.IDEXE_memRead = mr; ib.IDEXE_memRead = mr;
        ia.branch_taken_i = br; ib.branch_taken_i = br;
        ia.dmem_ready_i = rdy; ib.dmem_ready_i = rdy;
    end

    pipe_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(1), .PERF_W(16)) dut_a (
        .clk_i (clk), .rst_i (rst_n), .hz (ia.slave));
    pipe_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .PERF_W(4)) dut_b (
        .clk_i (clk), .rst_i (rst_n), .hz (ib.slave));

    logic [5:0] ctl_a, ctl_b;
    assign ctl_a = {ia.PC_write, ia.IFID_write, ia.control_output_select,
                    ia.IFID_flush_o, ia.IDEXE_flush_o, ia.pipe_freeze_o};
    assign ctl_b = {ib.PC_write, ib.IFID_write, ib.control_output_select,
                    ib.IFID_flush_o, ib.IDEXE_flush_o, ib.pipe_freeze_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic hit_now();
        return mr && rd != 0 && ((urs && rd == rs) || (urt && rd == rt));
    endfunction

    // {PC_write, IFID_write, bubble, IFID_flush, IDEXE_flush, freeze}
    function automatic logic [5:0] exp_ctl(input int d);
        if (!rst_n) return 6'b000000;
        if (!rdy) return 6'b000001;
        if (br) return 6'b100110;
        if (rem[d] > 0 || hit_now()) return 6'b001000;
        return 6'b110000;
    endfunction

    task automatic step();
        #1;
        chk("ctl_a", 32'(ctl_a), 32'(exp_ctl(0)));
        chk("ctl_b", 32'(ctl_b), 32'(exp_ctl(1)));
        chk("stall_a", 32'(ia.stall_cnt_o), sc[0]);
        chk("flush_a", 32'(ia.flush_cnt_o), fc[0]);
        chk("stall_b", 32'(ib.stall_cnt_o), sc[1]);
        chk("flush_b", 32'(ib.flush_cnt_o), fc[1]);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                rem[d] = 0; sc[d] = 0; fc[d] = 0;
            end else if (rdy) begin
                if (br) begin
                    rem[d] = 0;
                    fc[d] = (fc[d] < mx[d]) ? fc[d] + 1 : mx[d];
                end else if (rem[d] > 0 || hit_now()) begin
                    rem[d] = (rem[d] > 0) ? rem[d] - 1 : ls[d] - 1;
                    sc[d] = (sc[d] < mx[d]) ? sc[d] + 1 : mx[d];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic ua,
                         input logic ub, input logic [4:0] d, input logic m,
                         input logic t, input logic r, input logic n);
        rs = a; rt = b; urs = ua; urt = ub; rd = d; mr = m; br = t; rdy = r; rst_n = n;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin rem[d] = 0; sc[d] = 0; fc[d] = 0; end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) @(negedge clk);
        repeat (2) step();
        drive(1, 3, 1, 1, 4, 0, 0, 1, 1); step();
        // lw $2 in EXE, ID reads Rs=2
        drive(2, 5, 1, 1, 2, 1, 0, 1, 1); step();
        drive(2, 5, 1, 1, 2, 0, 0, 1, 1); repeat (3) step();
        chk("lu1_count", 32'(ia.stall_cnt_o), 1);
        chk("lu3_count", 32'(ib.stall_cnt_o), 3);
        drive(0, 0, 1, 1, 0, 1, 0, 1, 1); step();
        drive(1, 3, 1, 0, 3, 1, 0, 1, 1); step();
        chk("no_stall_count", 32'(ib.stall_cnt_o), 3);
        // freeze two cycles inside the stall burst
        drive(2, 5, 1, 1, 2, 1, 0, 1, 1); step();
        drive(2, 5, 1, 1, 2, 0, 0, 0, 1); repeat (2) step();
        drive(2, 5, 1, 1, 2, 0, 0, 1, 1); repeat (3) step();
        chk("freeze_count", 32'(ib.stall_cnt_o), 6);
        drive(2, 5, 1, 1, 2, 1, 1, 1, 1); step();
        drive(2, 5, 1, 1, 2, 1, 0, 1, 1); step();
        drive(2, 5, 1, 1, 2, 0, 1, 1, 1); step();
        drive(2, 5, 1, 1, 2, 0, 0, 1, 1); repeat (2) step();
        chk("flush_count", 32'(ib.flush_cnt_o), 2);
        drive(7, 7, 1, 0, 7, 1, 0, 1, 1); repeat (20) step();
        chk("sat_count", 32'(ib.stall_cnt_o), 15);
        drive(2, 5, 1, 1, 2, 1, 0, 1, 1); step();
        drive(2, 5, 1, 1, 2, 0, 0, 1, 0); step();
        drive(2, 5, 1, 1, 2, 0, 0, 1, 1); step();
        chk("reset_count", 32'(ib.stall_cnt_o), 0);
        repeat (400) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 49) != 0);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
